// File: rtl/gray_pkg.sv
// Shared definitions for the streaming grayscale converter:
// mode encodings and fixed-point luma constants.
package gray_pkg;

  typedef enum logic [1:0] {
    MODE_AVG  = 2'd0,
    MODE_LUMA = 2'd1,
    MODE_MAX  = 2'd2,
    MODE_INV  = 2'd3
  } gray_mode_e;

  localparam int LUMA_R         = 77;
  localparam int LUMA_G         = 150;
  localparam int LUMA_B         = 29;
  localparam int LUMA_RND       = 128;
  localparam int COEF_SHIFT_DEF = 8;

endpackage

// File: rtl/grayscale_stream_converter_if.sv
// Beat-level handshake bundle between the window fetcher,
// the grayscale converter and the kernel filter stages.
interface grayscale_stream_converter_if #(
  parameter int BPP        = 8,
  parameter int NUM_PIXELS = 9
);

  logic [1:0]                  mode;
  logic                        in_valid;
  logic                        in_ready;
  logic [NUM_PIXELS*3*BPP-1:0] in_rgb;
  logic                        out_valid;
  logic                        out_ready;
  logic [NUM_PIXELS*BPP-1:0]   out_gray;
  logic [1:0]                  out_mode;

  modport slave (
    input  mode, in_valid, in_rgb, out_ready,
    output in_ready, out_valid, out_gray, out_mode
  );

  modport master (
    output mode, in_valid, in_rgb, out_ready,
    input  in_ready, out_valid, out_gray, out_mode
  );

endinterface

// File: rtl/gray_pixel_core.sv
// Per-pixel two-stage datapath: stage 1 forms sum/weighted
// sum/max, stage 2 divides, shifts or inverts to a gray value.
module gray_pixel_core
  import gray_pkg::*;
#(
  parameter int BPP        = 8,
  parameter int COEF_SHIFT = COEF_SHIFT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_ld1,
  input  logic             i_ld2,
  input  gray_mode_e       i_mode,
  input  gray_mode_e       i_s1_mode,
  input  logic [3*BPP-1:0] i_rgb,
  output logic [BPP-1:0]   o_gray
);

  // Wide enough for the weighted sum, whose peak is M << COEF_SHIFT.
  localparam int W1 = BPP + COEF_SHIFT + 1;
  localparam logic [BPP-1:0] MAXG = BPP'((1 << BPP) - 1);

  logic [BPP-1:0] w_r;
  logic [BPP-1:0] w_g;
  logic [BPP-1:0] w_b;
  logic [BPP-1:0] w_max;
  logic [W1-1:0]  w_s1_next;
  logic [W1-1:0]  r_s1;
  logic [W1-1:0]  w_avg;
  logic [W1-1:0]  w_luma;
  logic [BPP-1:0] w_gray;
  logic [BPP-1:0] r_gray;

  assign w_r = i_rgb[3*BPP-1 -: BPP];
  assign w_g = i_rgb[2*BPP-1 -: BPP];
  assign w_b = i_rgb[BPP-1:0];

  always_comb begin
    w_max = w_r;
    if (w_g > w_max) w_max = w_g;
    if (w_b > w_max) w_max = w_b;
  end

  always_comb begin
    w_s1_next = '0;
    unique case (i_mode)
      MODE_AVG, MODE_INV:
        w_s1_next = W1'(w_r) + W1'(w_g) + W1'(w_b);
      MODE_LUMA:
        w_s1_next = W1'(LUMA_R) * W1'(w_r)
                  + W1'(LUMA_G) * W1'(w_g)
                  + W1'(LUMA_B) * W1'(w_b);
      MODE_MAX:
        w_s1_next = W1'(w_max);
      default:
        w_s1_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= '0;
    end else if (i_ld1) begin
      r_s1 <= w_s1_next;
    end
  end

  // Constant divide by 3 is exact integer floor division.
  assign w_avg  = r_s1 / W1'(3);
  assign w_luma = (r_s1 + W1'(LUMA_RND)) >> COEF_SHIFT;

  always_comb begin
    w_gray = '0;
    unique case (i_s1_mode)
      MODE_AVG:  w_gray = BPP'(w_avg);
      MODE_LUMA: w_gray = (w_luma > W1'(MAXG)) ? MAXG
                                               : BPP'(w_luma);
      MODE_MAX:  w_gray = BPP'(r_s1);
      MODE_INV:  w_gray = MAXG - BPP'(w_avg);
      default:   w_gray = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_gray <= '0;
    end else if (i_ld2) begin
      r_gray <= w_gray;
    end
  end

  assign o_gray = r_gray;

endmodule

// File: rtl/grayscale_stream_converter.sv
// Streaming RGB-to-gray converter: two-stage pipeline with
// per-beat mode and full valid/ready backpressure.
module grayscale_stream_converter
  import gray_pkg::*;
#(
  parameter int BIT_PER_PIXEL = 8,
  parameter int NUM_PIXELS    = 9,
  parameter int COEF_SHIFT    = COEF_SHIFT_DEF
) (
  input logic                          clk,
  input logic                          reset,
  grayscale_stream_converter_if.slave  bus
);

  localparam int BPP = BIT_PER_PIXEL;

  logic       r_s1_valid;
  logic       r_out_valid;
  gray_mode_e r_s1_mode;
  gray_mode_e r_out_mode;
  gray_mode_e w_in_mode;
  logic       w_en1;
  logic       w_en2;
  logic       w_acc;
  logic       w_ld2;

  logic [NUM_PIXELS*BPP-1:0] w_gray;

  assign w_en2       = !r_out_valid || bus.out_ready;
  assign w_en1       = !r_s1_valid || w_en2;
  assign bus.in_ready = w_en1 && !reset;
  assign w_acc       = bus.in_valid && bus.in_ready;
  assign w_ld2       = w_en2 && r_s1_valid;
  assign w_in_mode   = gray_mode_e'(bus.mode);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_s1_mode   <= MODE_AVG;
      r_out_mode  <= MODE_AVG;
    end else begin
      if (w_en1) r_s1_valid  <= w_acc;
      if (w_acc) r_s1_mode   <= w_in_mode;
      if (w_en2) r_out_valid <= r_s1_valid;
      if (w_ld2) r_out_mode  <= r_s1_mode;
    end
  end

  for (genvar i = 0; i < NUM_PIXELS; i++) begin : g_px
    gray_pixel_core #(
      .BPP       (BPP),
      .COEF_SHIFT(COEF_SHIFT)
    ) u_core (
      .clk      (clk),
      .reset    (reset),
      .i_ld1    (w_acc),
      .i_ld2    (w_ld2),
      .i_mode   (w_in_mode),
      .i_s1_mode(r_s1_mode),
      .i_rgb    (bus.in_rgb[3*BPP*i +: 3*BPP]),
      .o_gray   (w_gray[BPP*i +: BPP])
    );
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_mode  = r_out_mode;
  assign bus.out_gray  = w_gray;

endmodule
